// File: rtl/lc3_mem_arbiter.sv
// LC3 memory arbiter: shares one single-port memory between the instruction
// fetch port and the data port. Data accesses win by default, but a burst
// counter forces a waiting fetch through after MAX_DATA_BURST data grants.
// A watchdog aborts any access whose memory acknowledge never arrives.
module lc3_mem_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 1000,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instrmem_rd,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic              Data_rd,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              timeout_err
);

  localparam int BURST_W = (MAX_DATA_BURST > 0) ? $clog2(MAX_DATA_BURST + 1) : 1;
  localparam int WDOG_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);
  localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DONE} state_t;

  state_t              state;
  logic [BURST_W-1:0]  burst;
  logic [WDOG_W-1:0]   wdog;

  logic                in_access;
  logic                access_end;
  logic                data_grant;
  logic                instr_grant;
  logic [DATA_W-1:0]   ret_data;

  // Grant decision and access termination (ack or watchdog expiry); an
  // aborted access returns zero instead of whatever is on mem_rdata.
  always_comb begin
    in_access   = (state == INSTR) || (state == DATA);
    access_end  = in_access && (mem_ack || (wdog == WDOG_LAST));
    data_grant  = (state == IDLE) && data_req && !((burst == BURST_MAX) && instrmem_rd);
    instr_grant = (state == IDLE) && instrmem_rd && !data_grant;
    ret_data    = mem_ack ? mem_rdata : '0;
  end

  // Main sequencer: grants in IDLE, waits for ack or timeout, then one DONE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      burst          <= '0;
      wdog           <= '0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      Instr_dout     <= '0;
      Data_dout      <= '0;
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      complete_instr <= 1'b0;
      complete_data  <= 1'b0;
      case (state)
        IDLE: begin
          if (data_grant) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_addr  <= Data_addr;
            mem_we    <= ~Data_rd;
            mem_wdata <= Data_rd ? '0 : Data_din;
            wdog      <= '0;
            if (instrmem_rd) begin
              if (burst != BURST_MAX) burst <= burst + BURST_W'(1);
            end else begin
              burst <= '0;
            end
          end else if (instr_grant) begin
            state     <= INSTR;
            mem_req   <= 1'b1;
            mem_addr  <= pc;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wdog      <= '0;
            burst     <= '0;
          end
        end
        INSTR, DATA: begin
          if (access_end) begin
            state   <= DONE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            wdog    <= '0;
            if (!mem_ack) timeout_err <= 1'b1;
            if (state == INSTR) begin
              Instr_dout     <= ret_data;
              complete_instr <= 1'b1;
            end else begin
              if (!mem_we) Data_dout <= ret_data;
              complete_data <= 1'b1;
            end
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter: directed accesses against a behavioural memory
// with programmable wait states; expected completions go into a scoreboard
// queue that a monitor drains whenever a complete pulse appears.
module tb_lc3_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instrmem_rd = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] Instr_dout;
  logic        complete_instr;
  logic        data_req = 1'b0;
  logic        Data_rd = 1'b0;
  logic [15:0] Data_addr = '0;
  logic [15:0] Data_din = '0;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  int mem_waits = 0;
  bit mem_stall = 1'b0;
  int wcnt = 0;
  logic [15:0] mem_model [logic [15:0]];

  typedef struct {
    logic        is_instr;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  lc3_mem_arbiter #(
    .MAX_DATA_BURST(4),
    .TIMEOUT(8),
    .ADDR_W(16),
    .DATA_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .instrmem_rd(instrmem_rd),
    .pc(pc),
    .Instr_dout(Instr_dout),
    .complete_instr(complete_instr),
    .data_req(data_req),
    .Data_rd(Data_rd),
    .Data_addr(Data_addr),
    .Data_din(Data_din),
    .Data_dout(Data_dout),
    .complete_data(complete_data),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Memory model: acks after mem_waits stall cycles, never while mem_stall is set.
  always @(negedge clock) begin
    if (!mem_req) begin
      mem_ack = 1'b0;
      wcnt = 0;
    end else if (!mem_stall && wcnt >= mem_waits) begin
      mem_ack = 1'b1;
      if (mem_we) mem_model[mem_addr] = mem_wdata;
      mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'hDEAD;
    end else begin
      wcnt++;
    end
  end

  // Monitor: every complete pulse must match the head of the scoreboard.
  always @(negedge clock) begin
    if (reset && (complete_instr || complete_data)) begin
      checkOutput("both_complete", {31'd0, complete_instr && complete_data}, 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_complete", {31'd0, complete_instr}, {31'd0, complete_data});
        checkOutput("unexpected_complete_q", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("complete_kind", {31'd0, complete_instr}, {31'd0, e.is_instr});
        if (e.is_instr) checkOutput("Instr_dout", {16'd0, Instr_dout}, {16'd0, e.data});
        else            checkOutput("Data_dout", {16'd0, Data_dout}, {16'd0, e.data});
      end
    end
  end

  task automatic applyStimulus(input bit is_instr, input bit rd, input logic [15:0] addr,
                               input logic [15:0] wdata, input int waits, input bit stall,
                               input logic [15:0] exp_data, input int exp_lat, input bit hold_after);
    exp_t e;
    int cycles;
    bit done;
    @(negedge clock);
    mem_waits = waits;
    mem_stall = stall;
    if (is_instr) begin
      instrmem_rd = 1'b1;
      pc = addr;
    end else begin
      data_req = 1'b1;
      Data_rd = rd;
      Data_addr = addr;
      Data_din = wdata;
    end
    e.is_instr = is_instr;
    e.data = exp_data;
    exp_q.push_back(e);
    cycles = 0;
    done = 1'b0;
    while (!done && cycles < 100) begin
      @(posedge clock);
      #1;
      cycles++;
      if (cycles == 1) begin
        checkOutput("grant_req", {31'd0, mem_req}, 32'd1);
        checkOutput("grant_addr", {16'd0, mem_addr}, {16'd0, addr});
        checkOutput("grant_we", {31'd0, mem_we}, {31'd0, !is_instr && !rd});
        if (!is_instr && !rd) checkOutput("grant_wdata", {16'd0, mem_wdata}, {16'd0, wdata});
      end
      if (complete_instr || complete_data) done = 1'b1;
    end
    if (!done) begin
      checkOutput("complete_timeout", 32'd0, 32'd1);
      instrmem_rd = 1'b0;
      data_req = 1'b0;
      return;
    end
    checkOutput("latency", cycles, exp_lat);
    if (hold_after) begin
      @(posedge clock);
      #1;
      checkOutput("done_no_regrant", {31'd0, mem_req}, 32'd0);
    end
    instrmem_rd = 1'b0;
    data_req = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("req_low_after", {31'd0, mem_req}, 32'd0);
  endtask

  string order;
  logic  prev_req;
  int    grants;
  int    guard;

  initial begin
    mem_model[16'h3000] = 16'h1234;
    mem_model[16'h3002] = 16'h5A5A;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    checkOutput("rst_completes", {30'd0, complete_instr, complete_data}, 32'd0);
    checkOutput("rst_instr_dout", {16'd0, Instr_dout}, 32'd0);
    checkOutput("rst_data_dout", {16'd0, Data_dout}, 32'd0);
    checkOutput("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Fetch, zero wait, requester holds through the complete cycle
    applyStimulus(1'b1, 1'b1, 16'h3000, 16'h0000, 0, 1'b0, 16'h1234, 2, 1'b1);
    // Write with 3 waits leaves Data_dout at 0, then read it back
    applyStimulus(1'b0, 1'b0, 16'h4000, 16'hBEEF, 3, 1'b0, 16'h0000, 5, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h4000, 16'h0000, 3, 1'b0, 16'hBEEF, 5, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h4002, 16'h0F0F, 1, 1'b0, 16'hBEEF, 3, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h4002, 16'h0000, 0, 1'b0, 16'h0F0F, 2, 1'b0);

    // Fairness: both held, expect D,D,D,D,I,D,D,D,D,I
    order = "DDDDIDDDDI";
    for (int i = 0; i < 10; i++) begin
      exp_t e;
      e.is_instr = (order[i] == "I");
      e.data = e.is_instr ? 16'h1234 : 16'hBEEF;
      exp_q.push_back(e);
    end
    @(negedge clock);
    mem_waits = 0;
    pc = 16'h3000;
    Data_addr = 16'h4000;
    Data_rd = 1'b1;
    instrmem_rd = 1'b1;
    data_req = 1'b1;
    prev_req = 1'b0;
    grants = 0;
    guard = 0;
    while (grants < 10 && guard < 200) begin
      @(posedge clock);
      #1;
      guard++;
      if (mem_req && !prev_req) begin
        checkOutput("grant_order", {16'd0, mem_addr},
                    (order[grants] == "I") ? 32'h3000 : 32'h4000);
        grants++;
      end
      prev_req = mem_req;
    end
    checkOutput("grant_count", grants, 10);
    instrmem_rd = 1'b0;
    data_req = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("fair_drain", exp_q.size(), 0);

    // Watchdog on a fetch and on a data read; flag sticks through a good access
    applyStimulus(1'b1, 1'b1, 16'h3000, 16'h0000, 0, 1'b1, 16'h0000, 9, 1'b0);
    checkOutput("timeout_err_set", {31'd0, timeout_err}, 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h3002, 16'h0000, 2, 1'b0, 16'h5A5A, 4, 1'b0);
    checkOutput("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
    applyStimulus(1'b0, 1'b1, 16'h4000, 16'h0000, 0, 1'b1, 16'h0000, 9, 1'b0);
    checkOutput("timeout_err_sticky2", {31'd0, timeout_err}, 32'd1);

    // Reset in the middle of a data access
    @(negedge clock);
    mem_stall = 1'b1;
    Data_rd = 1'b1;
    Data_addr = 16'h4000;
    data_req = 1'b1;
    guard = 0;
    do begin
      @(posedge clock);
      #1;
      guard++;
    end while (!mem_req && guard < 20);
    checkOutput("midrst_req_seen", {31'd0, mem_req}, 32'd1);
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    data_req = 1'b0;
    #1;
    checkOutput("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
    checkOutput("midrst_data_dout", {16'd0, Data_dout}, 32'd0);
    repeat (2) @(negedge clock);
    mem_stall = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("midrst_no_req", {31'd0, mem_req}, 32'd0);

    applyStimulus(1'b1, 1'b1, 16'h3002, 16'h0000, 0, 1'b0, 16'h5A5A, 2, 1'b0);
    checkOutput("post_rst_timeout_err", {31'd0, timeout_err}, 32'd0);

    repeat (4) @(posedge clock);
    #1;
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lc3_mem_arbiter.md
Name: lc3_mem_arbiter

Overview:
Arbitrates one single-port unified memory between the LC3 instruction-fetch port and the LC3 data port. It sequences each access, waits on a variable-latency memory acknowledge, and returns data with one-cycle complete_instr/complete_data pulses. It sits between the LC3 core and the memory model. Data accesses take priority, bounded by a fairness counter, and a watchdog flags hung accesses.

Parameters:
MAX_DATA_BURST, 4, consecutive data grants allowed while an instruction fetch waits before the fetch is forced through
TIMEOUT, 1000, cycles to wait for mem_ack before aborting the access
ADDR_W, 16, address width
DATA_W, 16, data width

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instrmem_rd  input  1  instruction fetch request, held until complete_instr
pc  input  ADDR_W  fetch address
Instr_dout  output  DATA_W  fetched instruction, registered
complete_instr  output  1  one-cycle fetch-done pulse
data_req  input  1  data access request, held until complete_data
Data_rd  input  1  1=read, 0=write; valid with data_req
Data_addr  input  ADDR_W  data address
Data_din  input  DATA_W  write data
Data_dout  output  DATA_W  read data, registered
complete_data  output  1  one-cycle data-done pulse
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ack
mem_ack  input  1  memory completion, sampled while mem_req=1
timeout_err  output  1  sticky watchdog flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0: Instr_dout, Data_dout, complete_*, mem_*, timeout_err.
  - burst and wdog counters cleared.
  - mem_req drops immediately, including mid-access. An in-flight access is lost and no complete pulse is issued.
- States: IDLE, INSTR, DATA, DONE.
- IDLE:
  - Grant to data if data_req=1, unless burst==MAX_DATA_BURST and instrmem_rd=1, in which case grant to instr.
  - Otherwise grant to instr if instrmem_rd=1.
  - On the grant edge, register mem_addr and mem_we, and mem_wdata=Data_din for a data write. Assert mem_req and go to INSTR or DATA.
  - mem_we=1 only for a data grant with Data_rd=0.
- burst counter:
  - Increments on a data grant when instrmem_rd=1.
  - Clears on any instr grant, or on a data grant when instrmem_rd=0.
  - Saturates at MAX_DATA_BURST.
- INSTR/DATA:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable until the edge where mem_ack=1.
  - On that edge: mem_req, mem_we→0; capture mem_rdata into Instr_dout (INSTR) or into Data_dout (DATA read only). A DATA write leaves Data_dout unchanged.
  - Pulse complete_instr or complete_data for exactly one cycle, then go to DONE.
- Latency: request seen at edge N → mem_req high after edge N. If mem_ack=1 in that cycle, complete is high after edge N+1. Minimum 2 cycles request→complete; each memory wait cycle adds 1.
- DONE: one cycle, mem_req=0, requests ignored. This lets the requester drop its request after seeing complete. Then go to IDLE.
- Watchdog:
  - wdog counts cycles in INSTR/DATA with mem_ack=0 and clears on entry.
  - When wdog reaches TIMEOUT-1 and mem_ack=0: abort. mem_req→0, timeout_err→1 (sticky until reset), output data for a read forced to 0, the normal complete pulse issued, go to DONE.
- A request seen in IDLE is granted even if its requester drops it mid-access; the access always completes.
- Requests arriving in INSTR/DATA/DONE wait; no queueing beyond the held request signals.
- complete_instr and complete_data are never high in the same cycle.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Fetch only, zero-wait: pc=16'h3000, memory word 16'h1234 with mem_ack in the first mem_req cycle → mem_addr=3000, complete_instr 2 cycles after request, Instr_dout=16'h1234.
- Data write then read with 3 wait states: Data_addr=16'h4000, Data_rd=0, Data_din=16'hBEEF → mem_we=1, complete_data 5 cycles after request, Data_dout unchanged. Read of 4000 → Data_dout=16'hBEEF.
- Simultaneous requests, MAX_DATA_BURST=4, both held continuously → grant order D,D,D,D,I,D,D,D,D,I. Never both complete pulses in one cycle.
- Watchdog, TIMEOUT=8, mem_ack held 0 on a fetch → after 8 mem_req cycles: mem_req=0, complete_instr pulse, Instr_dout=0, timeout_err=1 stays high through later accesses until reset.
- Reset asserted mid-DATA with mem_req=1 → mem_req=0 immediately, no complete_data pulse. After release, a fetch of pc=16'h3002 completes normally.
- Requester drops request on the complete cycle → DONE prevents a duplicate grant; mem_req stays 0 for the following cycle.
